// File: rtl/tlc_pkg.sv
// Shared encodings and defaults for the traffic-light controller monitor.
// Phase values, monitor FSM states and default timing limits live here.
package tlc_pkg;

    localparam int unsigned G_MIN_DEF = 4;
    localparam int unsigned G_MAX_DEF = 16;
    localparam int unsigned Y_CYC_DEF = 2;

    typedef enum logic [2:0] {
        PH_WAIT = 3'd0,
        PH_NSG  = 3'd1,
        PH_NSY  = 3'd2,
        PH_EWG  = 3'd3,
        PH_EWY  = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        MON_UNSYNC    = 2'd0,
        MON_SYNC_PEND = 2'd1,
        MON_TRACK     = 2'd2
    } mon_state_e;

    // Legal successor in the NSG -> NSY -> EWG -> EWY -> NSG ring.
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_NSG:  return PH_NSY;
            PH_NSY:  return PH_EWG;
            PH_EWG:  return PH_EWY;
            PH_EWY:  return PH_NSG;
            default: return PH_WAIT;
        endcase
    endfunction

    function automatic logic is_green(input phase_e p);
        return (p == PH_NSG) || (p == PH_EWG);
    endfunction

    function automatic logic is_yellow(input phase_e p);
        return (p == PH_NSY) || (p == PH_EWY);
    endfunction

endpackage

// File: rtl/tlc_phase_decode.sv
// Combinational decode of the six observed light lines into a phase code.
module tlc_phase_decode
    import tlc_pkg::*;
(
    input  logic   ew_red_i,
    input  logic   ew_green_i,
    input  logic   ew_yellow_i,
    input  logic   ns_red_i,
    input  logic   ns_green_i,
    input  logic   ns_yellow_i,
    output phase_e phase_o
);

    always_comb begin
        phase_o = PH_WAIT;
        if (ew_red_i && ns_green_i) begin
            phase_o = PH_NSG;
        end else if (ew_red_i && ns_yellow_i) begin
            phase_o = PH_NSY;
        end else if (ew_green_i && ns_red_i) begin
            phase_o = PH_EWG;
        end else if (ew_yellow_i && ns_red_i) begin
            phase_o = PH_EWY;
        end
    end

endmodule

// File: rtl/tlc_monitor.sv
// Traffic-light controller monitor: tracks phase order and durations, flags errors.
// Optional completed-cycle counter enabled by defining TLC_MON_CYCLE_CNT_EN.
module tlc_monitor
    import tlc_pkg::*;
#(
    parameter int unsigned G_MIN = G_MIN_DEF,
    parameter int unsigned G_MAX = G_MAX_DEF,
    parameter int unsigned Y_CYC = Y_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EW_Red,
    input  logic       EW_Green,
    input  logic       EW_Yellow,
    input  logic       NS_Red,
    input  logic       NS_Green,
    input  logic       NS_Yellow,
    output logic [2:0] phase,
    output logic [7:0] dur_cnt,
    output logic       synced,
    output logic       err_conflict,
    output logic       err_seq,
    output logic       err_time,
    output logic       err_sticky,
    output logic [7:0] cycle_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    phase_e           phase_d;
    phase_e           phase_q;
    mon_state_e       state_q;
    logic [CNT_W-1:0] dur_d;
    logic [CNT_W-1:0] dur_q;
    logic             flagged_d;
    logic             flagged_q;
    logic             changed;
    logic             in_track;
    logic             hold_over;
    logic             green_bad;
    logic             conflict_d;
    logic             seq_d;
    logic             time_d;
    logic             conflict_q;
    logic             seq_q;
    logic             time_q;
    logic             sticky_q;

    tlc_phase_decode u_decode (
        .ew_red_i    (EW_Red),
        .ew_green_i  (EW_Green),
        .ew_yellow_i (EW_Yellow),
        .ns_red_i    (NS_Red),
        .ns_green_i  (NS_Green),
        .ns_yellow_i (NS_Yellow),
        .phase_o     (phase_d)
    );

    // Error conditions are evaluated against the change being registered this edge.
    always_comb begin
        changed    = (phase_d != phase_q);
        in_track   = (state_q == MON_TRACK);
        hold_over  = in_track && !changed && is_green(phase_q)
                     && (dur_q == CNT_W'(G_MAX));
        green_bad  = (dur_q < CNT_W'(G_MIN)) || (dur_q > CNT_W'(G_MAX));
        conflict_d = in_track && changed && (phase_d == PH_WAIT);
        seq_d      = in_track && changed && (phase_d != PH_WAIT)
                     && (phase_d != next_phase(phase_q));
        time_d     = hold_over
                     || (in_track && changed && is_green(phase_q) && green_bad && !flagged_q)
                     || (in_track && changed && is_yellow(phase_q) && (dur_q != CNT_W'(Y_CYC)));
        dur_d      = changed ? CNT_W'(1) : ((dur_q == CNT_MAX) ? CNT_MAX : dur_q + CNT_W'(1));
        flagged_d  = changed ? 1'b0 : (flagged_q || hold_over);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= PH_WAIT;
            dur_q      <= '0;
            state_q    <= MON_UNSYNC;
            flagged_q  <= 1'b0;
            conflict_q <= 1'b0;
            seq_q      <= 1'b0;
            time_q     <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            dur_q      <= dur_d;
            flagged_q  <= flagged_d;
            conflict_q <= conflict_d;
            seq_q      <= seq_d;
            time_q     <= time_d;
            sticky_q   <= sticky_q || conflict_d || seq_d || time_d;
            case (state_q)
                MON_UNSYNC: begin
                    if (phase_d != PH_WAIT) state_q <= MON_SYNC_PEND;
                end
                MON_SYNC_PEND: begin
                    if (changed) state_q <= (phase_d == PH_WAIT) ? MON_UNSYNC : MON_TRACK;
                end
                MON_TRACK: begin
                    if (phase_d == PH_WAIT) state_q <= MON_UNSYNC;
                end
                default: state_q <= MON_UNSYNC;
            endcase
        end
    end

`ifdef TLC_MON_CYCLE_CNT_EN
    logic [CNT_W-1:0] cyc_q;
    logic             wrap;

    assign wrap = (state_q == MON_TRACK) && (phase_q == PH_EWY) && (phase_d == PH_NSG);

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (wrap && (cyc_q != CNT_MAX)) begin
            cyc_q <= cyc_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cyc_q;
`else
    assign cycle_cnt = '0;
`endif

    assign phase        = phase_q;
    assign dur_cnt      = dur_q;
    assign synced       = (state_q == MON_TRACK);
    assign err_conflict = conflict_q;
    assign err_seq      = seq_q;
    assign err_time     = time_q;
    assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_tlc_monitor.sv
// Bench for tlc_monitor: directed scenarios plus random light sequences vs a behavioural model.
module tb_tlc_monitor;

    localparam int G_MIN = 4;
    localparam int G_MAX = 16;
    localparam int Y_CYC = 2;
`ifdef TLC_MON_CYCLE_CNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    // {EW_Red, EW_Green, EW_Yellow, NS_Red, NS_Green, NS_Yellow}
    localparam logic [5:0] L_NSG  = 6'b100_010;
    localparam logic [5:0] L_NSY  = 6'b100_001;
    localparam logic [5:0] L_EWG  = 6'b010_100;
    localparam logic [5:0] L_EWY  = 6'b001_100;
    localparam logic [5:0] L_CONF = 6'b010_010;
    localparam logic [5:0] L_OFF  = 6'b000_000;

    logic       clk;
    logic       reset;
    logic       EW_Red, EW_Green, EW_Yellow, NS_Red, NS_Green, NS_Yellow;
    logic [2:0] phase;
    logic [7:0] dur_cnt;
    logic       synced, err_conflict, err_seq, err_time, err_sticky;
    logic [7:0] cycle_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state: phase index, run length, sync level (0/1/2), green already flagged.
    int m_ph, m_len, m_sync, m_flag, m_cyc;
    bit m_conf, m_seq, m_time, m_sticky;

    tlc_monitor #(.G_MIN(G_MIN), .G_MAX(G_MAX), .Y_CYC(Y_CYC)) dut (
        .clk          (clk),
        .reset        (reset),
        .EW_Red       (EW_Red),
        .EW_Green     (EW_Green),
        .EW_Yellow    (EW_Yellow),
        .NS_Red       (NS_Red),
        .NS_Green     (NS_Green),
        .NS_Yellow    (NS_Yellow),
        .phase        (phase),
        .dur_cnt      (dur_cnt),
        .synced       (synced),
        .err_conflict (err_conflict),
        .err_seq      (err_seq),
        .err_time     (err_time),
        .err_sticky   (err_sticky),
        .cycle_cnt    (cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [5:0] l);
        if (l[5] && l[1]) return 1;
        if (l[5] && l[0]) return 2;
        if (l[4] && l[2]) return 3;
        if (l[3] && l[2]) return 4;
        return 0;
    endfunction

    task automatic model_step(input logic [5:0] l, input logic r);
        int  ph;
        bit  chg, trk;
        ph = decode(l);
        if (r) begin
            m_ph = 0; m_len = 0; m_sync = 0; m_flag = 0; m_cyc = 0;
            m_conf = 0; m_seq = 0; m_time = 0; m_sticky = 0;
            return;
        end
        chg    = (ph != m_ph);
        trk    = (m_sync == 2);
        m_conf = trk && ph == 0;
        m_seq  = trk && chg && ph != 0 && ph != (m_ph % 4) + 1;
        m_time = 0;
        if (trk && (m_ph == 1 || m_ph == 3)) begin
            if (!chg && m_len + 1 == G_MAX + 1) m_time = 1;
            if (chg && m_flag == 0 && (m_len < G_MIN || m_len > G_MAX)) m_time = 1;
        end
        if (trk && (m_ph == 2 || m_ph == 4) && chg && m_len != Y_CYC) m_time = 1;
        if (CYC_EN && trk && m_ph == 4 && ph == 1 && m_cyc < 255) m_cyc++;
        m_flag = chg ? 0 : (m_flag | int'(m_time));
        if (m_sync == 0) m_sync = (ph != 0) ? 1 : 0;
        else if (m_sync == 1) begin
            if (chg) m_sync = (ph == 0) ? 0 : 2;
        end else if (ph == 0) m_sync = 0;
        m_len    = chg ? 1 : ((m_len < 255) ? m_len + 1 : 255);
        m_ph     = ph;
        m_sticky = m_sticky | m_conf | m_seq | m_time;
    endtask

    task automatic compare_all();
        chk("phase",        int'(phase),        m_ph);
        chk("dur_cnt",      int'(dur_cnt),      m_len);
        chk("synced",       int'(synced),       int'(m_sync == 2));
        chk("err_conflict", int'(err_conflict), int'(m_conf));
        chk("err_seq",      int'(err_seq),      int'(m_seq));
        chk("err_time",     int'(err_time),     int'(m_time));
        chk("err_sticky",   int'(err_sticky),   int'(m_sticky));
        chk("cycle_cnt",    int'(cycle_cnt),    m_cyc);
    endtask

    task automatic tick(input logic [5:0] l, input logic r);
        {EW_Red, EW_Green, EW_Yellow, NS_Red, NS_Green, NS_Yellow} = l;
        reset = r;
        @(posedge clk);
        model_step(l, r);
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [5:0] l, input int n);
        for (int i = 0; i < n; i++) tick(l, 1'b0);
    endtask

    logic [5:0] ring [4];
    int pulses, pulse_dur, errs, idx;

    initial begin
        ring[0] = L_NSG; ring[1] = L_NSY; ring[2] = L_EWG; ring[3] = L_EWY;
        reset = 1'b1;
        {EW_Red, EW_Green, EW_Yellow, NS_Red, NS_Green, NS_Yellow} = L_OFF;

        // Reset state
        tick(L_OFF, 1'b1);
        tick(L_OFF, 1'b1);
        chk("rst_phase", int'(phase), 0);
        chk("rst_dur", int'(dur_cnt), 0);
        chk("rst_synced", int'(synced), 0);
        chk("rst_cycle", int'(cycle_cnt), 0);

        // Clean light cycle
        hold(L_NSG, 6);
        hold(L_NSY, 2);
        tick(L_EWG, 1'b0);
        chk("sync_at_ewg", int'(synced), 1);
        hold(L_EWG, 5);
        hold(L_EWY, 2);
        hold(L_NSG, 6);
        chk("clean_sticky", int'(err_sticky), 0);
        chk("clean_cycle", int'(cycle_cnt), CYC_EN ? 1 : 0);

        // Conflict while tracking
        tick(L_CONF, 1'b0);
        chk("conf_phase", int'(phase), 0);
        chk("conf_pulse", int'(err_conflict), 1);
        chk("conf_synced", int'(synced), 0);
        chk("conf_sticky", int'(err_sticky), 1);
        tick(L_NSG, 1'b0);
        chk("conf_once", int'(err_conflict), 0);
        hold(L_NSG, 4); hold(L_NSY, 2); hold(L_EWG, 6); hold(L_EWY, 2); hold(L_NSG, 6);

        // Out-of-order jump NSG -> EWG
        tick(L_EWG, 1'b0);
        chk("seq_pulse", int'(err_seq), 1);
        hold(L_EWG, 4);
        tick(L_EWY, 1'b0);
        chk("seq_resume", int'(err_seq), 0);
        hold(L_EWY, 1);

        // Overlong green then long yellow
        pulses = 0; pulse_dur = -1;
        for (int i = 0; i < 20; i++) begin
            tick(L_NSG, 1'b0);
            if (err_time) begin pulses++; pulse_dur = int'(dur_cnt); end
        end
        chk("long_g_pulses", pulses, 1);
        chk("long_g_at", pulse_dur, G_MAX + 1);
        tick(L_NSY, 1'b0);
        chk("long_g_exit", int'(err_time), 0);
        hold(L_NSY, 2);
        tick(L_EWG, 1'b0);
        chk("long_y_exit", int'(err_time), 1);

        // Short green
        hold(L_EWG, 2);
        tick(L_EWY, 1'b0);
        chk("short_g_exit", int'(err_time), 1);
        hold(L_EWY, 1); hold(L_NSG, 4); hold(L_NSY, 2); hold(L_EWG, 10);
        chk("pre_rst_dur", int'(dur_cnt), 10);

        // Reset mid-phase, then partial first phase
        tick(L_EWG, 1'b1);
        chk("mid_rst_phase", int'(phase), 0);
        chk("mid_rst_dur", int'(dur_cnt), 0);
        chk("mid_rst_errs", int'({err_conflict, err_seq, err_time, err_sticky, synced}), 0);
        chk("mid_rst_cycle", int'(cycle_cnt), 0);
        errs = 0;
        for (int i = 0; i < 11; i++) begin
            tick(i < 3 ? L_EWG : (i < 5 ? L_EWY : L_NSG), 1'b0);
            errs += int'(err_conflict) + int'(err_seq) + int'(err_time);
        end
        chk("partial_errs", errs, 0);
        chk("partial_sticky", int'(err_sticky), 0);

        // Duration saturation while unsynced
        tick(L_OFF, 1'b0);
        hold(L_OFF, 259);
        chk("dur_sat", int'(dur_cnt), 255);
        chk("wait_unsync_err", int'(err_sticky), 1);

        // Random light sequences
        idx = 0;
        for (int s = 0; s < 120; s++) begin
            int kind, n;
            kind = int'($urandom_range(0, 19));
            if (kind == 0) begin
                tick(ring[idx], 1'b1);
            end else if (kind == 1) begin
                hold(L_CONF, int'($urandom_range(1, 3)));
            end else if (kind == 2) begin
                hold(6'($urandom), int'($urandom_range(1, 3)));
            end else if (kind == 3) begin
                idx = int'($urandom_range(0, 3));
                hold(ring[idx], int'($urandom_range(1, 8)));
            end else begin
                idx = (idx + 1) % 4;
                n = (idx % 2 == 0) ? int'($urandom_range(G_MIN - 1, G_MAX + 3))
                                   : int'($urandom_range(Y_CYC - 1, Y_CYC + 1));
                hold(ring[idx], n);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
